// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states
// and the default datapath width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. The quotient/remainder
// outputs show the post-step values, so they are final in the cycle done is high.
module md_div_iter #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(ITERS + 1);

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // The partial remainder stays below the divisor, so one extra bit holds the shift.
  assign shifted   = {rem_reg, quo_reg[WIDTH-1]};
  assign fits      = (shifted >= {1'b0, dsr_reg});
  assign remainder = fits ? (shifted[WIDTH-1:0] - dsr_reg) : shifted[WIDTH-1:0];
  assign quotient  = {quo_reg[WIDTH-2:0], fits};
  assign done      = (count_reg == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsr_reg   <= '0;
    end else if (cancel) begin
      count_reg <= '0;
    end else if (start) begin
      quo_reg   <= dividend;
      rem_reg   <= '0;
      dsr_reg   <= divisor;
      count_reg <= CW'(ITERS);
    end else if (count_reg != '0) begin
      quo_reg   <= quotient;
      rem_reg   <= remainder;
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for EX. Results commit on the DONE
// edge, which is the edge on which the instruction leaves EX.
module md_hilo_ctrl
  import md_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int WIDTH     = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state;
  logic [WIDTH-1:0]   a_reg, b_reg, hi_reg, lo_reg;
  logic               signed_reg, neg_q_reg, neg_r_reg;
  logic [2*WIDTH-1:0] result_reg, ext_a, ext_b, product;

  logic             is_mul_op, is_div_op, is_signed_op, div_start, div_done;
  logic [WIDTH-1:0] rs_mag, rt_mag, div_quo, div_rem, quo_fix, rem_fix;

  assign is_mul_op    = op_valid && (op == MD_MULT || op == MD_MULTU);
  assign is_div_op    = op_valid && (op == MD_DIV || op == MD_DIVU);
  assign is_signed_op = (op == MD_MULT) || (op == MD_DIV);

  assign rs_mag    = (is_signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (is_signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign div_start = (state == ST_IDLE) && is_div_op && !flush;

  md_div_iter #(.WIDTH(WIDTH), .ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .cancel    (flush),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign quo_fix = neg_q_reg ? -div_quo : div_quo;
  assign rem_fix = neg_r_reg ? -div_rem : div_rem;

  // Sign-extending to full width makes the truncated product two's-complement correct.
  assign ext_a   = signed_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
  assign ext_b   = signed_reg ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
  assign product = ext_a * ext_b;

  assign stall_req = !flush && (((state == ST_IDLE) && (is_mul_op || is_div_op)) ||
                                (state == ST_MUL) || (state == ST_DIV));
  assign busy      = (state != ST_IDLE);
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mul_op) begin
            a_reg      <= rs_val;
            b_reg      <= rt_val;
            signed_reg <= is_signed_op;
            state      <= ST_MUL;
          end else if (is_div_op) begin
            neg_q_reg <= is_signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r_reg <= is_signed_op && rs_val[WIDTH-1];
            state     <= ST_DIV;
          end else if (op_valid && op == MD_MTHI) begin
            hi_reg <= rs_val;
          end else if (op_valid && op == MD_MTLO) begin
            lo_reg <= rs_val;
          end
        end
        ST_MUL: begin
          result_reg <= product;
          state      <= ST_DONE;
        end
        ST_DIV: begin
          if (div_done) begin
            result_reg <= {rem_fix, quo_fix};
            state      <= ST_DONE;
          end
        end
        default: begin
          hi_reg <= result_reg[2*WIDTH-1:WIDTH];
          lo_reg <= result_reg[WIDTH-1:0];
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Self-checking bench for md_hilo_ctrl: directed scenarios plus random ops against
// an arithmetic model of HI/LO and the expected stall counts.
module tb_md_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        stall_req, busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  md_hilo_ctrl #(.DIV_ITERS(32), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Reference: architectural HI/LO after one md instruction, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, h, l);
    longint      la, lb, sp;
    logic [63:0] up;
    logic [31:0] q, r, ua;
    la = int'(a);
    lb = int'(b);
    case (o)
      3'd1: begin sp = la * lb; return sp; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd3: begin
        if (b == 0) begin
          ua = a[31] ? -a : a;
          q  = 32'hFFFF_FFFF;
          r  = ua;
          if (a[31] != b[31]) q = -q;
          if (a[31]) r = -r;
        end else begin
          sp = la / lb;
          q  = sp[31:0];
          sp = la % lb;
          r  = sp[31:0];
        end
        return {r, q};
      end
      3'd4: begin
        if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
        else begin q = a / b; r = a % b; end
        return {r, q};
      end
      3'd5: return {a, l};
      3'd6: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return 2;
    if (o == 3'd3 || o == 3'd4) return 33;
    return 0;
  endfunction

  // Holds the instruction in EX until the stall drops, then lets it leave.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                        output int stalls, output bit timeout);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    stalls = 0; timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_req) begin timeout = 1'b0; break; end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h stalls=%0d", o, a, b, hi, lo, stalls);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b required 0/0/0/0", hi, lo, busy, stall_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [7] = '{3'd1, 3'd4, 3'd3, 3'd4, 3'd3, 3'd5, 3'd6};
    logic [31:0] t_a  [7] = '{32'hFFFF_FFFE, 32'd100, 32'hFFFF_FF9C, 32'h1234_5678,
                              32'h8000_0000, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    logic [31:0] t_b  [7] = '{32'd3, 32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_hi [7] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1234_5678,
                              32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [31:0] t_lo [7] = '{32'hFFFF_FFFA, 32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'h8000_0000, 32'h0BAD_F00D};
    int t_st [7] = '{2, 33, 33, 33, 33, 0, 0};
    int  st;
    bit  to;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], st, to);
      vectors++;
      if (to || st != t_st[i] || hi !== t_hi[i] || lo !== t_lo[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d]: hi=%h lo=%h stalls=%0d busy=%b required hi=%h lo=%h stalls=%0d busy=0",
                 i, hi, lo, st, busy, t_hi[i], t_lo[i], t_st[i]);
      end
    end
    model_hi = hi === t_hi[6] ? t_hi[6] : t_hi[6];
    model_lo = t_lo[6];
  endtask

  task automatic test_flush;
    int st;
    bit to;
    logic [63:0] exp;
    op_valid = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall_req=%b required 0", stall_req);
    end
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 3'd0;
    vectors++;
    if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
      errors++;
      $display("FAIL flush_state: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
               busy, hi, lo, model_hi, model_lo);
    end
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, to);
    exp = model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, model_hi, model_lo);
    vectors++;
    if (to || st != 2 || hi !== exp[63:32] || lo !== exp[31:0]) begin
      errors++;
      $display("FAIL flush_then_multu: hi=%h lo=%h stalls=%0d required hi=%h lo=%h stalls=2",
               hi, lo, st, exp[63:32], exp[31:0]);
    end
    model_hi = exp[63:32]; model_lo = exp[31:0];
  endtask

  task automatic test_reset_mid_div;
    op_valid = 1'b1; op = 3'd4; rs_val = 32'd12345; rt_val = 32'd17;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    rst = 1'b1; op_valid = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: hi=%h lo=%h busy=%b stall=%b required 0/0/0/0", hi, lo, busy, stall_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int st;
    bit to;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int n = 0; n < 24; n++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp = model(o, a, b, model_hi, model_lo);
      run_op(o, a, b, st, to);
      vectors++;
      if (to || st != exp_stalls(o) || hi !== exp[63:32] || lo !== exp[31:0] || busy !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] op=%0d rs=%h rt=%h: hi=%h lo=%h stalls=%0d required hi=%h lo=%h stalls=%0d",
                 n, o, a, b, hi, lo, st, exp[63:32], exp[31:0], exp_stalls(o));
      end
      model_hi = exp[63:32]; model_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
